// File: rtl/conv_window_sequencer.sv
// Frame-buffered K x K window generator: loads one frame over a pixel stream, then sweeps
// every strided window once per kernel and hands each one to the MAC datapath.
module conv_window_sequencer #(
   parameter int DATA_W      = 32,
   parameter int IMG_W       = 32,
   parameter int IMG_H       = 32,
   parameter int K           = 5,
   parameter int STRIDE      = 1,
   parameter int NUM_KERNELS = 6,
   localparam int OUT_W = (IMG_W - K) / STRIDE + 1,
   localparam int OUT_H = (IMG_H - K) / STRIDE + 1,
   localparam int KI_W  = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
   localparam int OR_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1,
   localparam int OC_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     pix_valid,
   output logic                     pix_ready,
   input  logic [DATA_W-1:0]        pix_data,
   output logic                     win_valid,
   input  logic                     win_ready,
   output logic [K*K*DATA_W-1:0]    win_data,
   output logic [KI_W-1:0]          win_kernel,
   output logic [OR_W-1:0]          win_row,
   output logic [OC_W-1:0]          win_col,
   output logic                     win_first,
   output logic                     win_klast,
   output logic                     win_last,
   output logic                     busy,
   output logic                     done
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int AW   = IW + 1;
   localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SWEEP, DONE} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] mem [NPIX];
   logic [AW-1:0]     wr_addr;
   logic [OR_W-1:0]   r;
   logic [OC_W-1:0]   c;
   logic [KI_W-1:0]   kernel;
   logic              pix_fire, win_fire, load_end;
   logic              c_end, r_end, k_end;

   assign pix_fire = (state == LOAD) && pix_valid;
   assign win_fire = (state == SWEEP) && win_ready;
   assign load_end = pix_fire && (wr_addr == LAST_PIX);
   assign c_end    = (c == OC_W'(OUT_W - 1));
   assign r_end    = (r == OR_W'(OUT_H - 1));
   assign k_end    = (kernel == KI_W'(NUM_KERNELS - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Handshake conditions use the raw valid/ready inputs so the ready outputs never feed back
   always_comb begin
      state_nxt = state;
      pix_ready = 1'b0;
      win_valid = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = LOAD;
         end
         LOAD: begin
            pix_ready = 1'b1;
            if (pix_valid && (wr_addr == LAST_PIX)) state_nxt = SWEEP;
         end
         SWEEP: begin
            win_valid = 1'b1;
            if (win_ready && c_end && r_end && k_end) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (pix_fire) mem[wr_addr[IW-1:0]] <= pix_data;
   end

   // Column advances first, then row, then kernel; counters hold while the window is stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_addr <= '0;
         r       <= '0;
         c       <= '0;
         kernel  <= '0;
      end else begin
         if ((state == IDLE) && start) wr_addr <= '0;
         else if (pix_fire)            wr_addr <= wr_addr + 1'b1;

         if (load_end) begin
            r      <= '0;
            c      <= '0;
            kernel <= '0;
         end else if (win_fire) begin
            if (c_end) begin
               c <= '0;
               if (r_end) begin
                  r <= '0;
                  if (k_end) kernel <= '0;
                  else       kernel <= kernel + 1'b1;
               end else begin
                  r <= r + 1'b1;
               end
            end else begin
               c <= c + 1'b1;
            end
         end
      end
   end

   for (genvar gi = 0; gi < K; gi++) begin : g_row
      for (genvar gj = 0; gj < K; gj++) begin : g_col
         logic [AW-1:0] addr;
         logic          addr_msb_unused;
         assign addr = (AW'(r) * AW'(STRIDE) + AW'(gi)) * AW'(IMG_W)
                     + AW'(c) * AW'(STRIDE) + AW'(gj);
         assign addr_msb_unused = addr[AW-1];
         assign win_data[(gi*K+gj)*DATA_W +: DATA_W] = mem[addr[IW-1:0]];
      end
   end

   assign win_kernel = kernel;
   assign win_row    = r;
   assign win_col    = c;
   assign win_first  = win_valid && (r == '0) && (c == '0);
   assign win_klast  = win_valid && r_end && c_end;
   assign win_last   = win_klast && k_end;

endmodule
